multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS control FSM that sequences the shared datapath: PC, IR, ALU, immediate extender, memory port and register file.
- Decodes the opcode and funct fields from the IR.
- Drives per-state enables and mux selects, including the extender's 2-bit extend-type select.
- Stalls on a single shared instruction/data memory port via a ready handshake.

---
 rtl/multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back over a shared datapath and a single ready-handshaked memory port.
module multicycle_ctrl #(
   parameter int MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic [1:0] ext_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_PASS = 3'b101;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HIGH = 2'b10;

   // R-type funct field to ALU operation; valid flag is separate
   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      logic [2:0] a;
      case (f)
         6'h21:   a = ALU_ADD;
         6'h23:   a = ALU_SUB;
         6'h24:   a = ALU_AND;
         6'h25:   a = ALU_OR;
         6'h2A:   a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // True when the opcode/funct pair is a supported instruction
   function automatic logic instr_legal(input logic [5:0] o, input logic [5:0] f);
      logic ok;
      case (o)
         OP_R: begin
            case (f)
               6'h21, 6'h23, 6'h24, 6'h25, 6'h2A: ok = 1'b1;
               default:                           ok = 1'b0;
            endcase
         end
         OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t     r_state;
   state_t     w_next;
   logic       w_mem_ready;
   logic       w_pc_write;
   logic       w_ir_write;
   logic [1:0] w_ext_op;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_op;
   logic [1:0] w_pc_src;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_instr_done;
   logic       w_illegal;

   // With waiting disabled the memory is modelled as zero-wait
   assign w_mem_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   // State register; reset aborts any instruction and restarts fetch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IF;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state control decode
   always_comb begin
      w_next       = S_IF;
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_ext_op     = EXT_ZERO;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_alu_op     = ALU_ADD;
      w_pc_src     = 2'b00;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_instr_done = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_IF: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            w_pc_write  = w_mem_ready;
            w_ir_write  = w_mem_ready;
            w_next      = w_mem_ready ? S_ID : S_IF;
         end
         S_ID: begin
            // ALU precomputes the branch target while decoding
            w_alu_src_b = 2'b11;
            w_ext_op    = EXT_SIGN;
            if (!instr_legal(op, funct)) begin
               w_illegal    = 1'b1;
               w_instr_done = 1'b1;
               w_next       = S_IF;
            end else if (op == OP_J) begin
               w_pc_write   = 1'b1;
               w_pc_src     = 2'b10;
               w_instr_done = 1'b1;
               w_next       = S_IF;
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            case (op)
               OP_R: begin
                  w_alu_src_a = 1'b1;
                  w_alu_op    = funct_alu(funct);
                  w_next      = S_WB;
               end
               OP_ORI: begin
                  w_alu_src_a = 1'b1;
                  w_alu_src_b = 2'b10;
                  w_alu_op    = ALU_OR;
                  w_next      = S_WB;
               end
               OP_LUI: begin
                  w_alu_src_b = 2'b10;
                  w_ext_op    = EXT_HIGH;
                  w_alu_op    = ALU_PASS;
                  w_next      = S_WB;
               end
               OP_LW, OP_SW: begin
                  w_alu_src_a = 1'b1;
                  w_alu_src_b = 2'b10;
                  w_ext_op    = EXT_SIGN;
                  w_next      = S_MEM;
               end
               OP_BEQ: begin
                  w_alu_src_a  = 1'b1;
                  w_alu_op     = ALU_SUB;
                  w_pc_src     = 2'b01;
                  w_pc_write   = zero;
                  w_instr_done = 1'b1;
                  w_next       = S_IF;
               end
               default: begin
                  w_next = S_IF;
               end
            endcase
         end
         S_MEM: begin
            if (op == OP_LW) begin
               w_mem_read = 1'b1;
               w_next     = w_mem_ready ? S_WB : S_MEM;
            end else if (op == OP_SW) begin
               w_mem_write  = 1'b1;
               w_instr_done = w_mem_ready;
               w_next       = w_mem_ready ? S_IF : S_MEM;
            end else begin
               w_next = S_IF;
            end
         end
         S_WB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
            w_reg_dst    = (op == OP_R);
            w_mem_to_reg = (op == OP_LW);
            w_next       = S_IF;
         end
         default: begin
            w_next = S_IF;
         end
      endcase
   end

   // Outputs are held at zero for the whole reset so nothing can be written
   always_comb begin
      if (rst) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         ext_op     = 2'b00;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 3'b000;
         pc_src     = 2'b00;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end else begin
         pc_write   = w_pc_write;
         ir_write   = w_ir_write;
         ext_op     = w_ext_op;
         alu_src_a  = w_alu_src_a;
         alu_src_b  = w_alu_src_b;
         alu_op     = w_alu_op;
         pc_src     = w_pc_src;
         mem_read   = w_mem_read;
         mem_write  = w_mem_write;
         reg_write  = w_reg_write;
         reg_dst    = w_reg_dst;
         mem_to_reg = w_mem_to_reg;
         instr_done = w_instr_done;
         illegal    = w_illegal;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side expands each
// instruction into its expected cycle-by-cycle control vectors; a monitor
// compares the DUT outputs against them on every falling edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, alu_src_a, mem_read, mem_write;
   logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
   logic [1:0] ext_op, alu_src_b, pc_src;
   logic [2:0] alu_op;

   int total = 0;
   int bad   = 0;

   logic [18:0] sb_q[$];
   string       tag_q[$];

   multicycle_ctrl #(.MEM_WAIT_EN(1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Expected control vector, same field order as the monitor packs the DUT
   function automatic logic [18:0] mk(
      input logic pcw, input logic irw, input logic [1:0] ext,
      input logic sa, input logic [1:0] sb, input logic [2:0] aop,
      input logic [1:0] ps, input logic mr, input logic mw, input logic rw,
      input logic rd, input logic m2r, input logic done, input logic ill);
      return {pcw, irw, ext, sa, sb, aop, ps, mr, mw, rw, rd, m2r, done, ill};
   endfunction

   // Instruction table: returns ALU op for R-type funct, 3'b111 if unknown
   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'h21:   return 3'b000;
         6'h23:   return 3'b001;
         6'h24:   return 3'b010;
         6'h25:   return 3'b011;
         6'h2A:   return 3'b100;
         default: return 3'b111;
      endcase
   endfunction

   function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) return (r_alu(f) != 3'b111);
      return (o == 6'h0D || o == 6'h0F || o == 6'h23 || o == 6'h2B ||
              o == 6'h04 || o == 6'h02);
   endfunction

   // Monitor: one comparison per queued expectation
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         logic [18:0] e, a;
         string t;
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         a = {pc_write, ir_write, ext_op, alu_src_a, alu_src_b, alu_op, pc_src,
              mem_read, mem_write, reg_write, reg_dst, mem_to_reg, instr_done, illegal};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s op=%h funct=%h: got %b expected %b", t, op, funct, a, e);
         end
      end
   end

   // One clock of stimulus plus its expected outputs
   task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic mr, input logic z, input logic [18:0] e,
                       input string t);
      @(posedge clk);
      #1;
      rst = r; op = o; funct = f; mem_ready = mr; zero = z;
      sb_q.push_back(e);
      tag_q.push_back(t);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference: expand one instruction into its cycle sequence
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input int wif, input int wmem);
      logic z;
      logic [18:0] e;
      bit ill;
      ill = !is_legal(o, f);
      for (int i = 0; i < wif; i++)
         step(1'b0, o, f, 1'b0, rb(), mk(0,0,2'b00,0,2'b01,3'b000,2'b00,1,0,0,0,0,0,0), "if_wait");
      step(1'b0, o, f, 1'b1, rb(), mk(1,1,2'b00,0,2'b01,3'b000,2'b00,1,0,0,0,0,0,0), "if");
      if (ill) begin
         step(1'b0, o, f, rb(), rb(), mk(0,0,2'b01,0,2'b11,3'b000,2'b00,0,0,0,0,0,1,1), "id_illegal");
         return;
      end
      if (o == 6'h02) begin
         step(1'b0, o, f, rb(), rb(), mk(1,0,2'b01,0,2'b11,3'b000,2'b10,0,0,0,0,0,1,0), "id_j");
         return;
      end
      step(1'b0, o, f, rb(), rb(), mk(0,0,2'b01,0,2'b11,3'b000,2'b00,0,0,0,0,0,0,0), "id");
      case (o)
         6'h00: e = mk(0,0,2'b00,1,2'b00,r_alu(f),2'b00,0,0,0,0,0,0,0);
         6'h0D: e = mk(0,0,2'b00,1,2'b10,3'b011,2'b00,0,0,0,0,0,0,0);
         6'h0F: e = mk(0,0,2'b10,0,2'b10,3'b101,2'b00,0,0,0,0,0,0,0);
         default: e = mk(0,0,2'b01,1,2'b10,3'b000,2'b00,0,0,0,0,0,0,0);
      endcase
      if (o == 6'h04) begin
         z = rb();
         step(1'b0, o, f, rb(), z, mk(z,0,2'b00,1,2'b00,3'b001,2'b01,0,0,0,0,0,1,0), "exe_beq");
         return;
      end
      step(1'b0, o, f, rb(), rb(), e, "exe");
      if (o == 6'h23) begin
         for (int i = 0; i < wmem; i++)
            step(1'b0, o, f, 1'b0, rb(), mk(0,0,2'b00,0,2'b00,3'b000,2'b00,1,0,0,0,0,0,0), "mem_lw_wait");
         step(1'b0, o, f, 1'b1, rb(), mk(0,0,2'b00,0,2'b00,3'b000,2'b00,1,0,0,0,0,0,0), "mem_lw");
      end else if (o == 6'h2B) begin
         for (int i = 0; i < wmem; i++)
            step(1'b0, o, f, 1'b0, rb(), mk(0,0,2'b00,0,2'b00,3'b000,2'b00,0,1,0,0,0,0,0), "mem_sw_wait");
         step(1'b0, o, f, 1'b1, rb(), mk(0,0,2'b00,0,2'b00,3'b000,2'b00,0,1,0,0,0,1,0), "mem_sw");
         return;
      end
      step(1'b0, o, f, rb(), rb(),
           mk(0,0,2'b00,0,2'b00,3'b000,2'b00,0,0,1,(o == 6'h00),(o == 6'h23),1,0), "wb");
   endtask

   // Directed cases first, then a randomized instruction stream
   initial begin
      logic [5:0] ops[10];
      logic [5:0] fns[7];
      ops = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h01, 6'h00};
      fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h07, 6'h00};

      step(1'b1, 6'h00, 6'h00, 1'b1, 1'b1, 19'd0, "reset");
      step(1'b1, 6'h00, 6'h00, 1'b1, 1'b1, 19'd0, "reset");

      // sw aborted by reset while waiting in the memory state
      step(1'b0, 6'h2B, 6'h00, 1'b1, 1'b0, mk(1,1,2'b00,0,2'b01,3'b000,2'b00,1,0,0,0,0,0,0), "rst_sw_if");
      step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(0,0,2'b01,0,2'b11,3'b000,2'b00,0,0,0,0,0,0,0), "rst_sw_id");
      step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(0,0,2'b01,1,2'b10,3'b000,2'b00,0,0,0,0,0,0,0), "rst_sw_exe");
      step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(0,0,2'b00,0,2'b00,3'b000,2'b00,0,1,0,0,0,0,0), "rst_sw_mem");
      step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 19'd0, "rst_mid_mem");
      step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 19'd0, "rst_hold");
      run_instr(6'h2B, 6'h00, 1, 0);

      run_instr(6'h00, 6'h21, 0, 0);
      run_instr(6'h0D, 6'h00, 0, 0);
      run_instr(6'h0F, 6'h00, 0, 0);
      run_instr(6'h23, 6'h00, 0, 2);
      run_instr(6'h04, 6'h00, 0, 0);
      run_instr(6'h04, 6'h00, 0, 0);
      run_instr(6'h3F, 6'h00, 0, 0);
      run_instr(6'h00, 6'h07, 0, 0);
      run_instr(6'h02, 6'h00, 2, 0);

      for (int n = 0; n < 200; n++) begin
         logic [5:0] o, f;
         o = ops[$urandom_range(0, 9)];
         f = fns[$urandom_range(0, 6)];
         if ($urandom_range(0, 9) == 0) o = 6'($urandom);
         run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
